// File: rtl/alu181_pkg.sv
// rtl/alu181_pkg.sv - shared constants and types for the 74181 nibble sequencer
package alu181_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Function selects (S3..S0) and modes for the operations the bench exercises
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic       M_ADD = 1'b0;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic       M_SUB = 1'b0;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic       M_XOR = 1'b1;

endpackage

// File: rtl/alu181_nibble_sequencer.sv
// rtl/alu181_nibble_sequencer.sv - drives a 4-bit 74181 core one nibble per cycle over a wide operand
module alu181_nibble_sequencer
  import alu181_pkg::*;
#(
  parameter int N_NIB = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*N_NIB-1:0] in_a,
  input  logic [NIB_W*N_NIB-1:0] in_b,
  input  logic [3:0]             in_s,
  input  logic                   in_m,
  input  logic                   in_cnb,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cnb,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cn4b,
  input  logic                   alu_aeb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*N_NIB-1:0] out_f,
  output logic                   out_cn4b,
  output logic                   out_aeb
);

  localparam int W  = NIB_W * N_NIB;
  localparam int KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_NIB - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic          aeb_acc_q, aeb_acc_d;
  logic [W-1:0]  out_f_q, out_f_d;
  logic          out_cn4b_q, out_cn4b_d;
  logic          out_aeb_q, out_aeb_d;

  // The core sees the current nibble straight from the operand registers; the
  // counter parks on the last nibble so the outputs stay put outside RUN.
  assign alu_a   = a_q[{k_q, 2'b00} +: NIB_W];
  assign alu_b   = b_q[{k_q, 2'b00} +: NIB_W];
  assign alu_s   = s_q;
  assign alu_m   = m_q;
  assign alu_cnb = carry_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_f     = out_f_q;
  assign out_cn4b  = out_cn4b_q;
  assign out_aeb   = out_aeb_q;

  // Next-state: capture in IDLE, one nibble per cycle in RUN, wait for consumer in DONE
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    m_d        = m_q;
    k_d        = k_q;
    carry_d    = carry_q;
    aeb_acc_d  = aeb_acc_q;
    out_f_d    = out_f_q;
    out_cn4b_d = out_cn4b_q;
    out_aeb_d  = out_aeb_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          s_d       = in_s;
          m_d       = in_m;
          carry_d   = in_cnb;
          k_d       = '0;
          aeb_acc_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        out_f_d[{k_q, 2'b00} +: NIB_W] = alu_f;
        carry_d   = alu_cn4b;
        aeb_acc_d = aeb_acc_q & alu_aeb;
        if (k_q == K_LAST) begin
          out_cn4b_d = alu_cn4b;
          out_aeb_d  = aeb_acc_q & alu_aeb;
          state_d    = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      k_q        <= '0;
      carry_q    <= 1'b1;
      aeb_acc_q  <= 1'b1;
      out_f_q    <= '0;
      out_cn4b_q <= 1'b1;
      out_aeb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      m_q        <= m_d;
      k_q        <= k_d;
      carry_q    <= carry_d;
      aeb_acc_q  <= aeb_acc_d;
      out_f_q    <= out_f_d;
      out_cn4b_q <= out_cn4b_d;
      out_aeb_q  <= out_aeb_d;
    end
  end

endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// tb/tb_alu181_nibble_sequencer.sv - self-checking bench for the nibble sequencer with a 74181 core model
module tb_alu181_nibble_sequencer;
  import alu181_pkg::*;

  localparam int N_NIB = 2;
  localparam int W     = 4 * N_NIB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_s;
  logic         in_m;
  logic         in_cnb;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cnb;
  logic [3:0]   alu_f;
  logic         alu_cn4b;
  logic         alu_aeb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_f;
  logic         out_cn4b;
  logic         out_aeb;

  int errors = 0;
  int checks = 0;

  alu181_nibble_sequencer #(.N_NIB(N_NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cnb(in_cnb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
    .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_cn4b(out_cn4b), .out_aeb(out_aeb)
  );

  // 74181 core, active-high data: arithmetic F = t1 plus t2 plus carry, logic F = ~(t1 ^ t2)
  logic [3:0] t1, t2;
  logic [4:0] sum5;
  always_comb begin
    t1       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    t2       = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
    sum5     = {1'b0, t1} + {1'b0, t2} + {4'b0, ~alu_cnb};
    alu_f    = alu_m ? ~(t1 ^ t2) : sum5[3:0];
    alu_cn4b = ~sum5[4];
    alu_aeb  = (alu_f == 4'hF);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, measure latency, check result and the return to IDLE
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cnb,
                        input logic [W-1:0] exp_f, input logic exp_c, input logic chk_c,
                        input logic exp_aeb);
    int edges;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({name, " ready"}, in_ready, 1'b1);
    in_a = a; in_b = b; in_s = s; in_m = m; in_cnb = cnb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    edges = 0;
    do begin
      tick();
      edges++;
      in_valid = 1'b0;
    end while (!out_valid && edges < 20);
    check({name, " latency"}, edges, N_NIB + 1);
    check({name, " out_f"}, out_f, exp_f);
    if (chk_c) check({name, " out_cn4b"}, out_cn4b, exp_c);
    check({name, " out_aeb"}, out_aeb, exp_aeb);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " back to idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cnb;
    logic [W-1:0] exp_f;
    logic         exp_c;
    logic         chk_c;
    logic         exp_aeb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int guard;
    vecs[0] = '{"add_3c_47",  8'h3C, 8'h47, S_ADD, M_ADD, 1'b1, 8'h83, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{"add_f0_20",  8'hF0, 8'h20, S_ADD, M_ADD, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"add_0f_cin", 8'h0F, 8'h00, S_ADD, M_ADD, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"sub_55_55",  8'h55, 8'h55, S_SUB, M_SUB, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{"sub_56_55",  8'h56, 8'h55, S_SUB, M_SUB, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"xor_a5_0f",  8'hA5, 8'h0F, S_XOR, M_XOR, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"add_ff_01",  8'hFF, 8'h01, S_ADD, M_ADD, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0; in_cnb = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_f", out_f, 8'h00);
    check("reset out_cn4b", out_cn4b, 1'b1);
    check("reset out_aeb", out_aeb, 1'b0);
    check("reset alu_a/b/s/m", {alu_a, alu_b, alu_s, alu_m}, 13'h0);
    check("reset alu_cnb", alu_cnb, 1'b1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cnb,
             vecs[i].exp_f, vecs[i].exp_c, vecs[i].chk_c, vecs[i].exp_aeb);
    end

    // Back-pressure, ignored request during RUN, back-to-back acceptance
    in_a = 8'h12; in_b = 8'h34; in_s = S_ADD; in_m = M_ADD; in_cnb = 1'b1;
    in_valid = 1'b1;
    tick();
    in_a = 8'h77; in_b = 8'h11;
    tick();
    check("bp in_ready during run", in_ready, 1'b0);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("bp out_valid", out_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp hold", {out_valid, in_ready, out_f}, {1'b1, 1'b0, 8'h46});
    end
    in_a = 8'h21; in_b = 8'h11; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b idle ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("b2b accepted", in_ready, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("b2b out_f", {out_valid, out_f}, {1'b1, 8'h32});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while in RUN
    in_a = 8'h99; in_b = 8'h22; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("abort in run", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 1'b1);
    check("abort out_valid", out_valid, 1'b0);
    check("abort out_f", out_f, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_reset_add", 8'h01, 8'h01, S_ADD, M_ADD, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu181_nibble_sequencer.md
Name: alu181_nibble_sequencer

Overview:
Multi-cycle controller placed directly upstream of the 4-bit 74181-style ALU core. It accepts a wide operation (A, B, S, M, active-low carry-in) through a valid/ready handshake. It then drives the ALU core one nibble per cycle, least-significant nibble first, and chains the active-low ripple carry (CN4b to CNb) through a register between nibbles. The assembled result, final carry and A=B flag are returned through an output valid/ready handshake.

Parameters:
N_NIB, 2, number of 4-bit nibbles per operation; legal range 1..4; data width W = 4*N_NIB

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  request present
in_ready  out  1  sequencer can accept a request
in_a  in  W  operand A
in_b  in  W  operand B
in_s  in  4  function select S3..S0
in_m  in  1  mode: 1 = logic, 0 = arithmetic
in_cnb  in  1  carry-in, active-low (74181 convention)
alu_a  out  4  nibble of A to the ALU core
alu_b  out  4  nibble of B to the ALU core
alu_s  out  4  function select to the ALU core
alu_m  out  1  mode to the ALU core
alu_cnb  out  1  carry-in to the ALU core, active-low
alu_f  in  4  ALU core result (combinational from alu_*)
alu_cn4b  in  1  ALU core carry-out, active-low
alu_aeb  in  1  ALU core A=B output
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_f  out  W  assembled result
out_cn4b  out  1  carry-out of the top nibble, active-low
out_aeb  out  1  AND of the per-nibble alu_aeb values

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: IDLE.
  - Register reset values: operand, S, M and nibble counter = 0; carry register = 1 (no carry); out_f = 0; out_cn4b = 1; out_aeb = 0.
  - Output reset values: in_ready = 1, out_valid = 0; alu_* outputs = 0 except alu_cnb = 1.
- Reset during RUN or DONE aborts the operation, discards all data and returns to IDLE.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE:
  - On in_valid & in_ready, capture in_a, in_b, in_s, in_m into registers.
  - Load the carry register with in_cnb, clear the nibble counter k, preset aeb_acc = 1, then go to RUN.
  - in_valid while not in IDLE is ignored; no capture happens.
- RUN: the alu_* outputs are combinational from registers.
  - alu_a = A_reg[4k+3:4k], alu_b = B_reg[4k+3:4k], alu_s = S_reg, alu_m = M_reg, alu_cnb = carry register.
  - At each clock edge:
    - out_f[4k+3:4k] <= alu_f
    - carry register <= alu_cn4b
    - aeb_acc <= aeb_acc & alu_aeb
    - k <= k+1
  - When k == N_NIB-1, go to DONE. On that edge, also load out_cn4b <= alu_cn4b and out_aeb <= aeb_acc & alu_aeb.
- DONE:
  - out_f, out_cn4b and out_aeb are held stable while out_valid = 1 and out_ready = 0.
  - On out_ready, go to IDLE at the next edge.
  - out_f is not cleared; it holds its last value until overwritten.
- Latency: acceptance edge, then N_NIB RUN cycles; out_valid rises N_NIB+1 edges after acceptance.
  - Minimum initiation interval is N_NIB+2 cycles (DONE to IDLE takes one cycle).
- M = 1: the carry is still chained and reported, but it is meaningless to the consumer. No special casing.
- In IDLE and DONE, the alu_* outputs hold their last values. Only the alu_* values during RUN are relied upon.
- The ALU core path is purely combinational within one cycle; the sequencer adds no pipeline stage in front of it.

Decomposition:
- Shared package alu181_pkg holds:
  - NIB_W = 4
  - state enum {IDLE, RUN, DONE}
  - S/M encodings used by the bench: ADD = 4'b1001 with M = 0; SUB = 4'b0110 with M = 0; XOR = 4'b0110 with M = 1.
- No sub-module. Nibble selection is an indexed part-select. The ALU core is instantiated beside the sequencer by the parent, not inside it.

Test Plan (N_NIB = 2, ALU core connected):
1. Add, no carries. ADD, cnb = 1, A = 0x3C, B = 0x47 -> out_f = 0x83, out_cn4b = 1. out_valid rises exactly 3 edges after acceptance.
2. Add with carry-out. ADD, cnb = 1, A = 0xF0, B = 0x20 -> out_f = 0x10, out_cn4b = 0. Also ADD, cnb = 0, A = 0x0F, B = 0x00 -> out_f = 0x10, which checks inter-nibble carry chaining.
3. Subtract equal operands. SUB, cnb = 1, A = B = 0x55 -> out_f = 0xFF, out_aeb = 1. Repeat with A = 0x56, B = 0x55 -> out_f = 0x00, out_aeb = 0, out_cn4b = 0.
4. Logic mode. XOR, A = 0xA5, B = 0x0F -> out_f = 0xAA.
5. Handshake back-pressure.
   - Hold out_ready = 0 for 5 cycles: out_valid stays 1, out_f stays stable, and in_ready stays 0.
   - A second in_valid during RUN is not captured.
   - A back-to-back request issued when in_ready returns is accepted and completes correctly.
6. Reset mid-operation. Assert rst_n = 0 during RUN -> state returns to IDLE immediately, in_ready = 1, out_valid = 0, out_f = 0. A following ADD of 0x01 + 0x01 gives 0x02.
